lmsm_sequencer: RTL and testbench

Multi-cycle sequencer for the Load-Multiple (LM, opcode 4'b0110) and Store-Multiple (SM, opcode 4'b0111) instructions.
- The main controller hands it the register mask IR[7:0] and a base address, then waits for done.
- It walks the set mask bits from R0 upward, issuing one memory access per set bit over a req/ack handshake.
- For LM, it writes each loaded word back to the register file.
- It replaces the controller's per-register counter loop, so memory wait states no longer stall on fixed timing.

---
 rtl/lmsm_sequencer_pkg.sv | 31 +++
 rtl/lmsm_sequencer_if.sv | 40 ++++
 rtl/lmsm_sequencer_lsb_prio_enc8.sv | 25 ++
 rtl/lmsm_sequencer.sv | 148 ++++++++++++++
 tb/tb_lmsm_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants and types for the LM/SM sequencer slice.
//   ADDR_W / DATA_W : memory address and data widths
//   NREG / IDX_W    : register count (mask width) and register index width
//   OP_LM / OP_SM   : opcodes that the main controller decodes
//   lmsm_state_t    : sequencer state encoding
//   mem_cmd_t       : memory request payload held stable while waiting for ack
package lmsm_sequencer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } lmsm_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Bundle of controller, memory and register-file signals around the sequencer.
//   slave  : the sequencer's view (consumes start/ack/read data, drives requests)
//   master : the environment's view (controller + memory + register file)
interface lmsm_sequencer_if;
  import lmsm_sequencer_pkg::*;

  // controller
  logic              start;
  logic              is_store;
  logic [NREG-1:0]   reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  // memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // register file
  logic [IDX_W-1:0]  rf_radd;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_wen;
  logic [IDX_W-1:0]  rf_wadd;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  start, is_store, reg_mask, base_addr, mem_ack, mem_rdata, rf_rdata,
    output busy, done, mem_req, mem_we, mem_addr, mem_wdata,
           rf_radd, rf_wen, rf_wadd, rf_wdata
  );

  modport master (
    output start, is_store, reg_mask, base_addr, mem_ack, mem_rdata, rf_rdata,
    input  busy, done, mem_req, mem_we, mem_addr, mem_wdata,
           rf_radd, rf_wen, rf_wadd, rf_wdata
  );

endinterface

// File: rtl/lmsm_sequencer_lsb_prio_enc8.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit mask.
//   i_mask    : mask to scan
//   o_idx_c   : index of lowest set bit (0 when mask is empty)
//   o_valid_c : 1 when any bit of the mask is set
module lsb_prio_enc8
  import lmsm_sequencer_pkg::*;
(
  input  logic [NREG-1:0]  i_mask,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx_c   = IDX_W'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer. Walks the set bits of a register
// mask from R0 upward, issuing one memory access per bit over req/ack and,
// for LM, writing each loaded word back to the register file.
//   clk      : clock, state updates on the falling edge
//   proc_rst : asynchronous active-low reset
//   bus      : controller (start/is_store/reg_mask/base_addr/busy/done),
//              memory (mem_req/we/addr/wdata/ack/rdata) and
//              register file (rf_radd/rdata, rf_wen/wadd/wdata)
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              proc_rst,
  lmsm_sequencer_if.slave   bus
);

  lmsm_state_t       r_state,    w_state_nxt;
  logic [NREG-1:0]   r_rem_mask, w_rem_mask_nxt;
  logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
  logic              r_st_q,     w_st_nxt;
  logic [IDX_W-1:0]  r_idx,      w_idx_nxt;

  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_mem_req,  w_mem_req_nxt;
  mem_cmd_t          r_mem_cmd,  w_mem_cmd_nxt;
  logic [IDX_W-1:0]  r_rf_radd,  w_rf_radd_nxt;
  logic              r_rf_wen,   w_rf_wen_nxt;
  logic [IDX_W-1:0]  r_rf_wadd,  w_rf_wadd_nxt;
  logic [DATA_W-1:0] r_rf_wdata, w_rf_wdata_nxt;

  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic [IDX_W-1:0]  w_enc_idx;
  logic              w_enc_valid;

  // Encoder looks at the next mask so rf_radd already points at the next
  // source register while in SCAN; SM store data is then captured on entry to REQ.
  lsb_prio_enc8 u_enc (
    .i_mask    (w_rem_mask_nxt),
    .o_idx_c   (w_enc_idx),
    .o_valid_c (w_enc_valid)
  );

  // State register and registered outputs.
  always_ff @(negedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      r_state    <= ST_IDLE;
      r_rem_mask <= '0;
      r_addr     <= '0;
      r_st_q     <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_cmd  <= '0;
      r_rf_radd  <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_wadd  <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem_mask <= w_rem_mask_nxt;
      r_addr     <= w_addr_nxt;
      r_st_q     <= w_st_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_cmd  <= w_mem_cmd_nxt;
      r_rf_radd  <= w_rf_radd_nxt;
      r_rf_wen   <= w_rf_wen_nxt;
      r_rf_wadd  <= w_rf_wadd_nxt;
      r_rf_wdata <= w_rf_wdata_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_mask_nxt  = r_rem_mask;
    w_addr_nxt      = r_addr;
    w_st_nxt        = r_st_q;
    w_idx_nxt       = r_idx;
    w_mem_wdata_nxt = '0;
    w_rf_wdata_nxt  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_rem_mask_nxt = bus.reg_mask;
          w_addr_nxt     = bus.base_addr;
          w_st_nxt       = bus.is_store;
          w_state_nxt    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_rem_mask == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          // r_rf_radd holds the lowest set bit of r_rem_mask here
          w_idx_nxt       = r_rf_radd;
          w_mem_wdata_nxt = r_st_q ? bus.rf_rdata : '0;
          w_state_nxt     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          w_rem_mask_nxt = r_rem_mask & ~(NREG'(1) << r_idx);
          w_addr_nxt     = r_addr + ADDR_W'(1);
          if (r_st_q) begin
            w_state_nxt = ST_SCAN;
          end else begin
            w_rf_wdata_nxt = bus.mem_rdata;
            w_state_nxt    = ST_WB;
          end
        end else begin
          w_mem_wdata_nxt = r_mem_cmd.wdata;
        end
      end
      ST_WB:   w_state_nxt = ST_SCAN;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they are valid for its whole cycle.
    w_busy_nxt          = (w_state_nxt != ST_IDLE);
    w_done_nxt          = (w_state_nxt == ST_DONE);
    w_mem_req_nxt       = (w_state_nxt == ST_REQ);
    w_mem_cmd_nxt.we    = (w_state_nxt == ST_REQ) && w_st_nxt;
    w_mem_cmd_nxt.addr  = (w_state_nxt == ST_REQ) ? w_addr_nxt : '0;
    w_mem_cmd_nxt.wdata = w_mem_wdata_nxt;
    w_rf_radd_nxt       = w_enc_valid ? w_enc_idx : '0;
    w_rf_wen_nxt        = (w_state_nxt == ST_WB);
    w_rf_wadd_nxt       = (w_state_nxt == ST_WB) ? w_idx_nxt : '0;
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_cmd.we;
  assign bus.mem_addr  = r_mem_cmd.addr;
  assign bus.mem_wdata = r_mem_cmd.wdata;
  assign bus.rf_radd   = r_rf_radd;
  assign bus.rf_wen    = r_rf_wen;
  assign bus.rf_wadd   = r_rf_wadd;
  assign bus.rf_wdata  = r_rf_wdata;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: a table of LM/SM transfers with
// hand-computed completion cycles, a memory responder with programmable wait
// states, and hand-written reset / stray-ack sequences.
module tb_lmsm_sequencer;
  import lmsm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic proc_rst;

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // register file model: Rn reads as 0xA000 + n
  assign bus.rf_rdata = 16'hA000 | DATA_W'(bus.rf_radd);

  typedef struct {
    logic        st;
    logic [7:0]  mask;
    logic [15:0] base;
    int          delay;     // wait cycles before each ack
    bit          noise;     // pulse start while busy
    bit          stray;     // hold mem_ack high outside REQ
    int          exp_done;  // cycle of done pulse after start edge
    int          exp_n;     // number of memory accesses
  } vec_t;

  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [15:0] acc_addr[$];
  logic        acc_we[$];
  logic [15:0] acc_wd[$];
  logic [2:0]  wr_idx[$];
  logic [15:0] wr_dat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.rf_wen,
                bus.mem_addr, bus.mem_wdata, bus.rf_radd, bus.rf_wadd, bus.rf_wdata});
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int          cyc, done_at, n_done, wait_cnt, k;
    logic        prev_req, prev_ack, prev_we;
    logic [15:0] prev_addr, prev_wd, ea;
    acc_addr.delete(); acc_we.delete(); acc_wd.delete();
    wr_idx.delete(); wr_dat.delete();
    done_at = -1; n_done = 0; wait_cnt = 0; cyc = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wd = '0;

    @(posedge clk);
    check($sformatf("v%0d_idle_before", vi), 64'(bus.busy), 64'(0));
    bus.start = 1'b1; bus.is_store = v.st; bus.reg_mask = v.mask; bus.base_addr = v.base;
    bus.mem_ack = v.stray;

    while (cyc < v.exp_done + 3) begin
      @(posedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (bus.rf_wen) begin
        wr_idx.push_back(bus.rf_wadd);
        wr_dat.push_back(bus.rf_wdata);
      end
      if (prev_req && !prev_ack && bus.mem_req)
        check($sformatf("v%0d_req_stable_c%0d", vi, cyc),
              64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
              64'({prev_we, prev_addr, prev_wd}));
      // memory responder
      if (!bus.mem_req) begin
        wait_cnt = 0;
        bus.mem_ack = v.stray;
        bus.mem_rdata = 16'hDEAD;
      end else if (wait_cnt >= v.delay) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h5000 ^ bus.mem_addr;
        acc_addr.push_back(bus.mem_addr);
        acc_we.push_back(bus.mem_we);
        acc_wd.push_back(bus.mem_wdata);
      end else begin
        wait_cnt++;
        bus.mem_ack = 1'b0;
      end
      prev_req = bus.mem_req; prev_ack = bus.mem_ack;
      prev_we = bus.mem_we; prev_addr = bus.mem_addr; prev_wd = bus.mem_wdata;
      // start pulses while busy must be ignored
      if (v.noise && (cyc == 3 || cyc == v.exp_done)) begin
        bus.start = 1'b1; bus.is_store = ~v.st; bus.reg_mask = 8'hFF; bus.base_addr = 16'hBEEF;
      end
    end
    bus.mem_ack = 1'b0;

    check($sformatf("v%0d_done_cycle", vi), 64'(done_at), 64'(v.exp_done));
    check($sformatf("v%0d_done_pulses", vi), 64'(n_done), 64'(1));
    check($sformatf("v%0d_busy_after", vi), 64'({bus.busy, bus.done, bus.mem_req}), 64'(0));
    check($sformatf("v%0d_n_access", vi), 64'(acc_addr.size()), 64'(v.exp_n));
    check($sformatf("v%0d_n_rfwrite", vi), 64'(wr_idx.size()), 64'(v.st ? 0 : v.exp_n));

    // reference walk: R0 upward, consecutive addresses wrapping at 16 bits
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (v.mask[i]) begin
        ea = v.base + 16'(k);
        if (k < acc_addr.size()) begin
          check($sformatf("v%0d_addr%0d", vi, k), 64'(acc_addr[k]), 64'(ea));
          check($sformatf("v%0d_we%0d", vi, k), 64'(acc_we[k]), 64'(v.st));
          if (v.st)
            check($sformatf("v%0d_wdata%0d", vi, k), 64'(acc_wd[k]), 64'(16'hA000 + 16'(i)));
        end
        if (!v.st && k < wr_idx.size()) begin
          check($sformatf("v%0d_rf_idx%0d", vi, k), 64'(wr_idx[k]), 64'(i));
          check($sformatf("v%0d_rf_data%0d", vi, k), 64'(wr_dat[k]), 64'(16'h5000 ^ ea));
        end
        k++;
      end
    end
  endtask

  initial begin
    bit seen;
    //            st    mask   base      dly noise stray done n
    vecs[0] = '{1'b0, 8'h05, 16'h0010, 0, 1'b0, 1'b0,  8, 2};
    vecs[1] = '{1'b1, 8'hFF, 16'hFFFE, 0, 1'b0, 1'b0, 18, 8};
    vecs[2] = '{1'b0, 8'h00, 16'h1234, 0, 1'b0, 1'b0,  2, 0};
    vecs[3] = '{1'b1, 8'h00, 16'h4321, 0, 1'b0, 1'b0,  2, 0};
    vecs[4] = '{1'b0, 8'h80, 16'h0200, 3, 1'b1, 1'b0,  8, 1};
    vecs[5] = '{1'b1, 8'h81, 16'h7FFF, 1, 1'b0, 1'b1,  8, 2};
    vecs[6] = '{1'b0, 8'h0A, 16'h0100, 0, 1'b0, 1'b1,  8, 2};
    vecs[7] = '{1'b0, 8'hFF, 16'hFFFF, 0, 1'b0, 1'b0, 26, 8};
    vecs[8] = '{1'b0, 8'h0F, 16'h0040, 0, 1'b0, 1'b0, 14, 4};

    proc_rst = 1'b0;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.reg_mask = '0; bus.base_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    check("reset_outputs", outs(), 64'(0));
    proc_rst = 1'b1;

    // stray ack in IDLE: nothing starts
    bus.mem_ack = 1'b1;
    repeat (4) @(posedge clk);
    check("idle_stray_ack", 64'({bus.busy, bus.mem_req, bus.rf_wen}), 64'(0));
    bus.mem_ack = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // reset while an LM waits in REQ
    @(posedge clk);
    bus.start = 1'b1; bus.is_store = 1'b0; bus.reg_mask = 8'h0F; bus.base_addr = 16'h0040;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      bus.start = 1'b0;
      if (bus.mem_req) seen = 1'b1;
    end
    check("rst_reached_req", 64'(seen), 64'(1));
    #2 proc_rst = 1'b0;
    #1 check("rst_async_clear", outs(), 64'(0));
    repeat (3) begin
      @(posedge clk);
      check("rst_hold_quiet", 64'({bus.done, bus.rf_wen, bus.mem_req}), 64'(0));
    end
    proc_rst = 1'b1;
    run_vec(vecs[8], 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
